// File: rtl/pmu_mem_pkg.sv
// Shared widths, clear depth and FSM encoding for the memory arbiter slice.
package pmu_mem_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 8;
    localparam int DEPTH_DEF = 256;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin pick: on a conflict the pointer names the winner and
// then moves to the loser; single requests win without moving it.
module mem_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);

    always_comb begin
        gnt     = 2'b00;
        ptr_nxt = ptr;
        unique case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                gnt     = ptr ? 2'b10 : 2'b01;
                ptr_nxt = ~ptr;
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory, with a zeroize
// engine that sweeps every word after reset or on request, and a write lock.
module mem_arbiter
    import pmu_mem_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_start,
    input  logic          lock_set,
    output logic          clr_busy,
    output logic          locked,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic          err1,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_e    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          locked_q, locked_d;
    logic          ptr_q, ptr_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic          err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic [1:0]    pick_gnt;
    logic          pick_ptr_nxt;
    logic          arb_en;

    mem_rr_pick u_pick (
        .req     ({req1, req0}),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .ptr_nxt (pick_ptr_nxt)
    );

    // A clr_start in IDLE wins over any request in the same cycle.
    assign arb_en = (state_q == ST_IDLE) && !clr_start;
    assign gnt0   = arb_en && pick_gnt[0];
    assign gnt1   = arb_en && pick_gnt[1];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_cnt_q;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                end else if (gnt0) begin
                    mem_we    = we0;
                    mem_addr  = addr0;
                    mem_wdata = wdata0;
                end else if (gnt1) begin
                    // Locked writes are still granted but never reach the array.
                    mem_we    = we1 && !locked_q;
                    mem_addr  = addr1;
                    mem_wdata = wdata1;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_comb begin
        locked_d  = locked_q | lock_set;
        ptr_d     = arb_en ? pick_ptr_nxt : ptr_q;
        rvalid0_d = gnt0 && !we0;
        rvalid1_d = gnt1 && !we1;
        err1_d    = gnt1 && we1 && locked_q;
        rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            locked_q  <= 1'b0;
            ptr_q     <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            locked_q  <= locked_d;
            ptr_q     <= ptr_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign locked   = locked_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign err1     = err1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock and reset ports are named clk and rst_n.
REQ-002 Parameters (name, default, meaning): DW, 32, data width; AW, 8, address width; DEPTH, 256, words zeroized by the clear engine.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- clr_start  in  1  one-cycle pulse requesting full zeroize
- lock_set  in  1  pulse; sets the sticky write lock for requester 1
- clr_busy  out  1  clear engine active
- locked  out  1  write lock state
- req0 / req1  in  1  access request, requester 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  access accepted this cycle
- rdata0 / rdata1  out  DW  registered read data
- rvalid0 / rvalid1  out  1  rdata valid, one-cycle pulse
- err1  out  1  one-cycle pulse: requester-1 write dropped by lock
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data (combinational read)

Function
REQ-004 FSM states: CLEAR and IDLE; reset state is CLEAR.
REQ-005 In CLEAR:
- mem_we=1, mem_addr=clr_cnt, mem_wdata=0;
- clr_cnt increments at each edge;
- after the write at DEPTH-1, the FSM goes to IDLE and clr_cnt wraps to 0;
- the clear therefore takes exactly DEPTH cycles.
REQ-006 clr_busy SHALL be 1 exactly while the state is CLEAR; gnt0 and gnt1 SHALL be 0 in CLEAR, and requests stall without being lost.
REQ-007 In IDLE, a clr_start pulse SHALL move the FSM to CLEAR at the next edge; a request in the same cycle is not granted (clear wins).
REQ-008 clr_start while in CLEAR SHALL be ignored; the clear does not restart.
REQ-009 Arbitration in IDLE:
- grant is combinational, at most one gnt per cycle;
- if only one req is high, it wins;
- if both are high, the winner is given by a round-robin pointer, and the pointer then points at the loser;
- the pointer resets to 0 and does not move when nothing is granted.
REQ-010 The granted requester's we, addr and wdata SHALL drive mem_we, mem_addr and mem_wdata in the grant cycle; a write commits at that edge.
REQ-011 A granted read SHALL capture mem_rdata into that requester's rdata at the grant edge and pulse its rvalid the following cycle (latency 1); rdata holds until the next read.
REQ-012 locked is sticky: lock_set sets it, and only rst_n clears it.
REQ-013 While locked, a granted write from requester 1 SHALL be granted but drive mem_we=0, and err1 pulses the next cycle; reads from requester 1 and all accesses from requester 0 are unaffected.
REQ-014 In IDLE with no grant, mem_we=0, mem_addr=0 and mem_wdata=0.

Reset
REQ-015 While rst_n is low, register outputs SHALL be: state CLEAR, clr_cnt 0, clr_busy 1, locked 0, pointer 0, rvalid0/1 0, err1 0, rdata0/1 0, gnt0/1 0.
REQ-016 While rst_n is low, mem_we=1, mem_addr=0 and mem_wdata=0 (a benign zero write).
REQ-017 Reset asserted mid-clear or mid-access SHALL abort the operation; after release the clear restarts from address 0 and runs the full DEPTH cycles.

Structure
REQ-018 DW, AW, DEPTH and the FSM state encoding SHALL live in a shared package, pmu_mem_pkg.
REQ-019 The round-robin pick (two req bits plus pointer in; grant vector and next pointer out) SHALL be one sub-module, mem_rr_pick.
REQ-020 mem_arbiter drives the existing single-port memory through the mem_* port and contains no storage array itself.

Verification
REQ-021 Release rst_n:
- clr_busy stays 1 for exactly 256 cycles;
- mem_addr runs 0..255 with mem_we=1 and mem_wdata=0;
- clr_busy falls and the state is IDLE.
REQ-022 Write 0xDEADBEEF to address 0x10 via requester 0, then read 0x10 via requester 1:
- gnt1 is high in the grant cycle;
- rvalid1 pulses one cycle later with rdata1=0xDEADBEEF.
REQ-023 Hold req0 and req1 high for 4 cycles from the reset pointer: the grant sequence is 0,1,0,1.
REQ-024 Pulse lock_set, then have requester 1 write 0x12345678 to address 0x20:
- gnt1=1 with mem_we=0;
- err1 pulses;
- a requester-0 read of 0x20 returns 0.
REQ-025 Pulse clr_start together with req0 in IDLE:
- gnt0=0 in that cycle;
- a 256-cycle clear follows;
- req0 held high is granted in the first IDLE cycle.
REQ-026 Assert rst_n low at clear address 100, then release: the clear restarts at address 0 and locked=0.
